vector_writeback: RTL and testbench

- Serialises a vector result of up to LANES elements into the register file through its single scalar write port (we3/wa3/wd3), one element per unhazarded cycle.
- Lane i is written to register base+i.
- Sits between the vector execute stage and the register file. It is the write-side counterpart of the register file's vector read path.
- A hold input lets scalar writeback take priority on the shared write port.

---
 rtl/vector_writeback.sv | 136 +++++++++++++
 tb/tb_vector_writeback.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_writeback.sv
// Vector writeback serialiser: drains up to LANES captured elements into the
// register file's single scalar write port, yielding to scalar writeback on hold.
module vector_writeback #(
    parameter int LANES = 5,
    parameter int DW    = 32,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [AW-1:0]       base_wa,
    input  logic [3:0]          count,
    input  logic [LANES*DW-1:0] vdata,
    input  logic                hold,
    output logic                ready,
    output logic                busy,
    output logic                we3,
    output logic [AW-1:0]       wa3,
    output logic [DW-1:0]       wd3,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // r15 is the PC; vector lanes landing there are dropped and flagged.
    localparam logic [AW-1:0] PC_ADDR = '1;
    localparam logic [3:0]    LANES_C = 4'(LANES);

    state_t               state_reg, state_next;
    logic [3:0]           k_reg, k_next;
    logic [3:0]           n_reg, n_next;
    logic [AW-1:0]        base_reg, base_next;
    logic [LANES*DW-1:0]  data_reg, data_next;
    logic                 err_reg, err_next;

    logic [DW-1:0]        lane_data [LANES];
    logic [DW-1:0]        lane_sel;
    logic [AW-1:0]        addr;
    logic [3:0]           n_clamp;
    logic                 in_write;
    logic                 last_lane;
    logic                 to_pc;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_data[gi] = data_reg[gi*DW +: DW];
        end
    endgenerate

    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < LANES; i++) begin
            if (k_reg == 4'(i)) begin
                lane_sel = lane_data[i];
            end
        end
    end

    // Destination wraps modulo the register file size.
    assign addr      = base_reg + AW'(k_reg);
    assign n_clamp   = (count > LANES_C) ? LANES_C : count;
    assign in_write  = (state_reg == WRITE);
    assign last_lane = (k_reg == (n_reg - 4'd1));
    assign to_pc     = (addr == PC_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            n_reg     <= '0;
            base_reg  <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            n_reg     <= n_next;
            base_reg  <= base_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        n_next     = n_reg;
        base_next  = base_reg;
        data_next  = data_reg;
        err_next   = err_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    data_next  = vdata;
                    base_next  = base_wa;
                    n_next     = n_clamp;
                    k_next     = '0;
                    err_next   = 1'b0;
                    state_next = (n_clamp != 4'd0) ? WRITE : DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                // A PC-targeted lane still consumes its slot so later lanes keep their addresses.
                if (!hold) begin
                    k_next = k_reg + 4'd1;
                    if (to_pc) begin
                        err_next = 1'b1;
                    end
                    if (last_lane) begin
                        state_next = DONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready = (state_reg == IDLE) || (state_reg == DONE);
    assign busy  = in_write;
    assign we3   = in_write && !hold && !to_pc;
    assign wa3   = (in_write && !hold) ? addr : '0;
    assign wd3   = (in_write && !hold) ? lane_sel : '0;
    assign done  = (state_reg == DONE);
    assign err   = (state_reg == DONE) && err_reg;

endmodule

// File: tb/tb_vector_writeback.sv
// Directed bench for vector_writeback: expected register writes are queued at
// start and retired against we3/wa3/wd3 as the unit drains them.
module tb_vector_writeback;

    localparam int LANES = 5;
    localparam int DW    = 32;
    localparam int AW    = 4;

    logic                clk;
    logic                reset;
    logic                start;
    logic [AW-1:0]       base_wa;
    logic [3:0]          count;
    logic [LANES*DW-1:0] vdata;
    logic                hold;
    logic                ready;
    logic                busy;
    logic                we3;
    logic [AW-1:0]       wa3;
    logic [DW-1:0]       wd3;
    logic                done;
    logic                err;

    int total  = 0;
    int passed = 0;

    logic [AW+DW-1:0] sb_q [$];

    vector_writeback #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .base_wa (base_wa),
        .count   (count),
        .vdata   (vdata),
        .hold    (hold),
        .ready   (ready),
        .busy    (busy),
        .we3     (we3),
        .wa3     (wa3),
        .wd3     (wd3),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [LANES*DW-1:0] pack5(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                   input logic [DW-1:0] c, input logic [DW-1:0] d,
                                                   input logic [DW-1:0] e);
        return {e, d, c, b, a};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one transfer from the cycle start is driven until done (or a cycle budget expires).
    // hmask bit c drives hold in cycle c after the accepting edge; poke re-pulses start in cycle 2.
    task automatic xfer(input string tag, input logic [AW-1:0] b, input logic [3:0] c,
                        input logic [LANES*DW-1:0] d, input logic [31:0] hmask, input bit poke,
                        input bit exp_err, input int exp_done_cycle);
        int n;
        int cyc;
        bit seen_done;
        logic [AW-1:0] a;
        logic [AW+DW-1:0] item;
        n = (int'(c) > LANES) ? LANES : int'(c);
        for (int k = 0; k < n; k++) begin
            a = b + AW'(k);
            if (a != 4'hF) sb_q.push_back({a, d[k*DW +: DW]});
        end
        start   = 1'b1;
        base_wa = b;
        count   = c;
        vdata   = d;
        hold    = 1'b0;
        next_cycle();
        start     = 1'b0;
        seen_done = 1'b0;
        cyc       = 1;
        hold      = hmask[1];
        while (!seen_done && cyc < 40) begin
            @(negedge clk);
            chk({tag, " busy"}, {63'd0, busy}, {63'd0, !done});
            chk({tag, " ready"}, {63'd0, ready}, {63'd0, done});
            if (hold) begin
                chk({tag, " held port"}, {27'd0, we3, wa3, wd3}, 64'd0);
            end
            if (we3) begin
                if (sb_q.size() == 0) begin
                    chk({tag, " unexpected write"}, {28'd0, wa3, wd3}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    item = sb_q.pop_front();
                    $display("%s: cycle %0d write r%0d <= %08h", tag, cyc, wa3, wd3);
                    chk({tag, " write"}, {28'd0, wa3, wd3}, {28'd0, item});
                end
            end
            if (done) begin
                seen_done = 1'b1;
                $display("%s: done in cycle %0d err=%0d", tag, cyc, err);
                chk({tag, " done cycle"}, 64'(cyc), 64'(exp_done_cycle));
                chk({tag, " err"}, {63'd0, err}, {63'd0, exp_err});
                chk({tag, " pending writes"}, 64'(sb_q.size()), 64'd0);
            end else begin
                next_cycle();
                cyc++;
                hold = hmask[cyc];
                if (poke && cyc == 2) begin
                    start   = 1'b1;
                    base_wa = 4'd9;
                    count   = 4'd1;
                    vdata   = pack5(32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD);
                end else begin
                    start = 1'b0;
                end
            end
        end
        if (!seen_done) begin
            chk({tag, " done timeout"}, 64'd0, 64'd1);
        end
        sb_q.delete();
        hold = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " ready"}, {63'd0, ready}, 64'd1);
        chk({tag, " outputs"}, {24'd0, busy, we3, wa3, wd3, done, err}, 64'd0);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        base_wa = '0;
        count   = '0;
        vdata   = '0;
        hold    = 1'b0;

        #3;
        check_idle("reset");
        $display("reset: ready=%0d busy=%0d we3=%0d done=%0d", ready, busy, we3, done);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();

        xfer("basic", 4'd2, 4'd3, pack5(32'h11, 32'h22, 32'h33, 32'h0, 32'h0), 32'h0, 1'b0, 1'b0, 4);
        next_cycle();
        check_idle("basic idle");

        xfer("hold", 4'd0, 4'd2, pack5(32'hA0, 32'hA1, 32'h0, 32'h0, 32'h0), 32'h4, 1'b0, 1'b0, 4);
        next_cycle();

        xfer("wrap", 4'd14, 4'd3, pack5(32'hAAAA, 32'hBBBB, 32'hCCCC, 32'h0, 32'h0), 32'h0, 1'b0, 1'b1, 4);
        next_cycle();

        xfer("count0", 4'd6, 4'd0, pack5(32'h1, 32'h2, 32'h3, 32'h4, 32'h5), 32'h0, 1'b0, 1'b0, 1);
        next_cycle();

        xfer("count9", 4'd3, 4'd9, pack5(32'h51, 32'h52, 32'h53, 32'h54, 32'h55), 32'h0, 1'b0, 1'b0, 6);
        next_cycle();

        xfer("poke", 4'd5, 4'd4, pack5(32'h61, 32'h62, 32'h63, 32'h64, 32'h0), 32'h0, 1'b1, 1'b0, 5);
        next_cycle();
        check_idle("poke idle");

        xfer("b2b_a", 4'd8, 4'd2, pack5(32'h71, 32'h72, 32'h0, 32'h0, 32'h0), 32'h0, 1'b0, 1'b0, 3);
        xfer("b2b_b", 4'd12, 4'd2, pack5(32'h81, 32'h82, 32'h0, 32'h0, 32'h0), 32'h0, 1'b0, 1'b0, 3);
        next_cycle();
        check_idle("b2b idle");

        start   = 1'b1;
        base_wa = 4'd1;
        count   = 4'd5;
        vdata   = pack5(32'h91, 32'h92, 32'h93, 32'h94, 32'h95);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("rst lane0", {27'd0, we3, wa3, wd3}, {27'd0, 1'b1, 4'd1, 32'h91});
        next_cycle();
        @(negedge clk);
        chk("rst lane1", {27'd0, we3, wa3, wd3}, {27'd0, 1'b1, 4'd2, 32'h92});
        #1;
        reset = 1'b0;
        #1;
        $display("async reset: we3=%0d busy=%0d done=%0d ready=%0d", we3, busy, done, ready);
        check_idle("async reset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post reset", {61'd0, we3, busy, ready}, 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
